// File: rtl/clk_cmd_ctrl.sv
// Command sequencer for the mm:ss clock/alarm datapath.
// Parses "l"/"a" + four digits + CR from the UART, commits the digits one
// load strobe per cycle, gates the clock run enable, runs the alarm
// off/armed/triggered FSM and returns a one-byte ack to the UART tx path.
module clk_cmd_ctrl #(
   parameter int unsigned TIMEOUT_S = 5,
   parameter int unsigned TO_W      = 4,
   parameter logic [7:0]  ACK_OK    = 8'h4B,
   parameter logic [7:0]  ACK_ERR   = 8'h3F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bu_rx_data_rdy,
   input  logic [7:0] bu_rx_data,
   input  logic       oneSecStrb,
   input  logic       did_alarmMatch,
   input  logic       tx_busy,
   output logic [7:0] dicLdVec,
   output logic [3:0] dicLdData,
   output logic       dicRun,
   output logic [1:0] dicAlarmState,
   output logic       L3_tx_data_rdy,
   output logic [7:0] L3_tx_data,
   output logic       cmd_err
);

   localparam logic [7:0] CH_L  = 8'h6C;
   localparam logic [7:0] CH_A  = 8'h61;
   localparam logic [7:0] CH_AT = 8'h40;
   localparam logic [7:0] CH_CR = 8'h0D;

   typedef enum logic [1:0] {IDLE, DIG, WAIT_CR, COMMIT} state_t;
   typedef enum logic [1:0] {AL_OFF = 2'b00, AL_ARMED = 2'b01, AL_TRIG = 2'b10} alarm_t;

   state_t          state_q, state_n;
   alarm_t          al_q, al_n;
   logic [1:0]      idx_q, idx_n;        // digit index while parsing, strobe index while committing
   logic            tgt_q, tgt_n;        // 0 = time registers, 1 = alarm registers
   logic [3:0][3:0] dig_q, dig_n;
   logic [TO_W-1:0] to_q, to_n;
   logic            pend_q;
   logic [7:0]      pend_byte_q;

   logic            ack_set;
   logic [7:0]      ack_val;
   logic            err_set;
   logic            abort;
   logic            at_toggle;
   logic            to_hit;
   logic            ack_have;
   logic [7:0]      ack_byte;

   // Tens positions only go to 5 (minutes and seconds both stop at 59).
   function automatic logic digit_ok(input logic [1:0] i, input logic [7:0] b);
      logic [7:0] lim;
      lim = i[0] ? 8'h39 : 8'h35;
      return (b >= 8'h30) && (b <= lim);
   endfunction

   assign to_hit = (TIMEOUT_S != 0) && oneSecStrb && (to_q == TO_W'(TIMEOUT_S - 1));
   assign dicAlarmState = al_q;

   // State registers for the command parser and the alarm FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         al_q    <= AL_OFF;
         idx_q   <= 2'd0;
         tgt_q   <= 1'b0;
         dig_q   <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_n;
         al_q    <= al_n;
         idx_q   <= idx_n;
         tgt_q   <= tgt_n;
         dig_q   <= dig_n;
         to_q    <= to_n;
      end
   end

   // Next-state logic, load strobes, run gating and ack/error requests.
   always_comb begin
      state_n   = state_q;
      al_n      = al_q;
      idx_n     = idx_q;
      tgt_n     = tgt_q;
      dig_n     = dig_q;
      to_n      = to_q;
      ack_set   = 1'b0;
      ack_val   = ACK_OK;
      err_set   = 1'b0;
      abort     = 1'b0;
      at_toggle = 1'b0;
      dicLdVec  = 8'h00;
      dicLdData = 4'h0;
      dicRun    = (state_q == IDLE);
      case (state_q)
         IDLE: begin
            to_n = '0;
            if (bu_rx_data_rdy) begin
               if (bu_rx_data == CH_L || bu_rx_data == CH_A) begin
                  tgt_n   = (bu_rx_data == CH_A);
                  idx_n   = 2'd0;
                  state_n = DIG;
               end else if (bu_rx_data == CH_AT) begin
                  at_toggle = 1'b1;
                  ack_set   = 1'b1;
               end
            end
         end
         DIG: begin
            if (bu_rx_data_rdy) begin
               to_n = '0;
               if (digit_ok(idx_q, bu_rx_data)) begin
                  dig_n[idx_q] = bu_rx_data[3:0];
                  idx_n        = idx_q + 2'd1;
                  if (idx_q == 2'd3) state_n = WAIT_CR;
               end else begin
                  abort = 1'b1;
               end
            end else if (to_hit) begin
               abort = 1'b1;
            end else if (oneSecStrb) begin
               to_n = to_q + 1'b1;
            end
         end
         WAIT_CR: begin
            if (bu_rx_data_rdy) begin
               to_n = '0;
               if (bu_rx_data == CH_CR) begin
                  idx_n   = 2'd0;
                  state_n = COMMIT;
               end else begin
                  abort = 1'b1;
               end
            end else if (to_hit) begin
               abort = 1'b1;
            end else if (oneSecStrb) begin
               to_n = to_q + 1'b1;
            end
         end
         COMMIT: begin
            dicLdVec  = tgt_q ? (8'h08 >> idx_q) : (8'h80 >> idx_q);
            dicLdData = dig_q[idx_q];
            idx_n     = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_n = IDLE;
               ack_set = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (abort) begin
         state_n = IDLE;
         idx_n   = 2'd0;
         dig_n   = '0;
         to_n    = '0;
         err_set = 1'b1;
         ack_set = 1'b1;
         ack_val = ACK_ERR;
      end
      case (al_q)
         AL_OFF:   if (at_toggle) al_n = AL_ARMED;
         AL_ARMED: begin
            if (at_toggle) al_n = AL_OFF;
            else if (did_alarmMatch && oneSecStrb) al_n = AL_TRIG;
         end
         AL_TRIG:  if (at_toggle) al_n = AL_OFF;
         default:  al_n = AL_OFF;
      endcase
      ack_have = ack_set | pend_q;
      ack_byte = ack_set ? ack_val : pend_byte_q;
   end

   // Single-slot ack buffer: newest ack wins, launched as soon as tx is free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q         <= 1'b0;
         pend_byte_q    <= 8'h00;
         L3_tx_data_rdy <= 1'b0;
         L3_tx_data     <= 8'h00;
         cmd_err        <= 1'b0;
      end else begin
         cmd_err <= err_set;
         if (ack_have && !tx_busy) begin
            L3_tx_data_rdy <= 1'b1;
            L3_tx_data     <= ack_byte;
            pend_q         <= 1'b0;
         end else begin
            L3_tx_data_rdy <= 1'b0;
            pend_q         <= ack_have;
            if (ack_have) pend_byte_q <= ack_byte;
         end
      end
   end

endmodule

// File: doc/clk_cmd_ctrl.md
Name: clk_cmd_ctrl

Overview:
- Command sequencer for the mm:ss clock/alarm datapath. Parses UART bytes "l", "a" and "@", validates digits and buffers all four.
- On carriage return, commits the four digits atomically: one load strobe per cycle into the time or alarm digit registers.
- Also owns run gating, the alarm off/armed/triggered FSM, and a one-byte ack to the UART tx path.

Parameters:
- TIMEOUT_S, 5: seconds without an accepted byte mid-command before abort; 0 disables the timeout.
- TO_W, 4: width of the timeout counter; must satisfy TIMEOUT_S < 2**TO_W.
- ACK_OK, 8'h4B: ack byte 'K' for success.
- ACK_ERR, 8'h3F: ack byte '?' for error or abort.

Ports:
- clk  in  1  global clock
- rst  in  1  asynchronous, active-low reset
- bu_rx_data_rdy  in  1  one-cycle strobe, rx byte valid
- bu_rx_data  in  8  rx byte
- oneSecStrb  in  1  one-cycle strobe per second
- did_alarmMatch  in  1  raw time==alarm compare from the datapath
- tx_busy  in  1  UART tx cannot accept a byte
- dicLdVec  out  8  one-hot load strobes {Mtens,Mones,Stens,Sones,AMtens,AMones,AStens,ASones}
- dicLdData  out  4  digit value for the active strobe
- dicRun  out  1  clock may count
- dicAlarmState  out  2  00 off, 01 armed, 10 triggered
- L3_tx_data_rdy  out  1  one-cycle ack strobe
- L3_tx_data  out  8  ack byte
- cmd_err  out  1  one-cycle pulse on any rejected command

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; digit buffer = 0; timeout counter = 0; ack not pending.
  - dicLdVec=0, dicLdData=0, dicRun=1, dicAlarmState=00, L3_tx_data_rdy=0, L3_tx_data=0, cmd_err=0.
- Byte consumption: a byte is consumed only in a cycle with bu_rx_data_rdy=1. bu_rx_data is ignored otherwise.
- Main FSM states: IDLE, DIG, WAIT_CR, COMMIT.
- IDLE:
  - 'l' (0x6C) selects target=time; 'a' (0x61) selects target=alarm. Either moves to DIG with idx=0.
  - '@' (0x40) is handled by the alarm FSM and queues ACK_OK.
  - Any other byte is ignored silently.
- DIG (idx 0..3):
  - idx 0 and 2 accept 0x30..0x35; idx 1 and 3 accept 0x30..0x39.
  - A valid digit stores its low nibble in buf[idx] and increments idx; after idx 3 go to WAIT_CR.
  - An invalid byte aborts.
- WAIT_CR: 0x0D goes to COMMIT; any other byte aborts.
- Run gating: dicRun=0 from the cycle after the l/a byte until COMMIT completes, and in every cycle the FSM is outside IDLE.
- COMMIT (CR consumed in cycle N):
  - Cycles N+1..N+4 drive exactly one dicLdVec bit, in order tens-min, ones-min, tens-sec, ones-sec of the selected target.
  - dicLdData = buf[0..3] in the same cycles.
  - FSM returns to IDLE at N+5; dicRun=1 from N+5; ACK_OK queued at N+5.
  - rx bytes arriving during COMMIT are dropped.
- Abort:
  - No load strobes; digit buffer discarded; return to IDLE next cycle.
  - cmd_err pulses one cycle and ACK_ERR is queued.
  - dicRun returns to 1; clock digits are unchanged.
- Timeout:
  - Counter increments on oneSecStrb while in DIG or WAIT_CR; clears on each consumed byte and on entering IDLE.
  - Counter reaching TIMEOUT_S aborts.
  - A consumed byte in the same cycle as the terminal strobe wins: the byte is processed, no abort.
- Alarm FSM:
  - OFF, on '@' in IDLE → ARMED.
  - ARMED, on '@' → OFF.
  - ARMED, on did_alarmMatch & oneSecStrb → TRIG.
  - TRIG, on '@' → OFF.
  - '@' and a qualified match in the same cycle: '@' wins.
  - An alarm-value commit does not change alarm state.
  - '@' received outside IDLE is a digit error and aborts; it does not toggle.
- Ack tx:
  - One pending slot. When pending and tx_busy=0: L3_tx_data_rdy=1 for one cycle, L3_tx_data=byte, slot clears.
  - While tx_busy=1 the byte is held.
  - A new ack while one is pending overwrites it (latest wins).
  - L3_tx_data holds its last value between strobes.

Test Plan:
- Time set: "l","1","2","3","4",CR with rdy pulses spaced 10 cycles, tx_busy=0 → dicLdVec 8'h80/40/20/10 with data 1/2/3/4 in CR+1..CR+4; dicRun 0→1 at CR+5; L3_tx_data=0x4B strobe at CR+5.
- Range error: "l","6" → no dicLdVec activity; cmd_err pulse; ack 0x3F; dicRun back to 1.
- Alarm: "a","0","0","0","5",CR then "@" → dicLdVec 8'h08/04/02/01 with data 0,0,0,5; state 01; drive did_alarmMatch=1 with oneSecStrb → state 10; "@" → 00.
- Collision: ARMED, '@' rdy in the same cycle as match&oneSecStrb → state 00, never 10.
- Timeout: "l","1" then 5 oneSecStrb, no bytes → abort after the 5th strobe, ack 0x3F; a byte on the 5th-strobe cycle prevents the abort.
- Ack backpressure/reset: tx_busy=1 across two acks → a single strobe carrying the later byte after tx_busy falls; rst low mid-COMMIT → outputs immediately return to reset values, no further strobes.
